// File: rtl/issue_stall_ctrl.sv
// rtl/issue_stall_ctrl.sv - issue-stage stall controller with RS/ROB credit counters and flush window
module issue_stall_ctrl #(
   parameter  int NUM_CLS      = 3,
   parameter  int RS_DEPTH     = 4,
   parameter  int ROB_DEPTH    = 16,
   parameter  int FLUSH_CYCLES = 2,
   localparam int CLS_W        = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1,
   localparam int RS_CW        = $clog2(RS_DEPTH + 1),
   localparam int ROB_CW       = $clog2(ROB_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   input  logic [CLS_W-1:0]           issue_class,
   input  logic [NUM_CLS-1:0]         rs_release,
   input  logic                       rob_commit,
   input  logic                       flush,
   input  logic                       pc_locked,
   output logic                       issue_fire,
   output logic                       pc_stall,
   output logic                       icache_stall,
   output logic [NUM_CLS*RS_CW-1:0]   rs_free,
   output logic [ROB_CW-1:0]          rob_free,
   output logic                       in_flush,
   output logic                       credit_err
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [RS_CW-1:0]  RS_FULL  = RS_CW'(RS_DEPTH);
   localparam logic [ROB_CW-1:0] ROB_FULL = ROB_CW'(ROB_DEPTH);
   localparam logic [FC_W-1:0]   FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_FLUSH
   } state_t;

   state_t            state;
   logic [FC_W-1:0]   flush_cnt;
   logic [RS_CW-1:0]  rs_cnt [NUM_CLS];
   logic [ROB_CW-1:0] rob_cnt;
   logic              err_q;

   logic              cls_ok;
   logic              res_ok;
   logic [RS_CW-1:0]  sel_free;
   logic [NUM_CLS-1:0] rs_take;

   // Resource check for the presented instruction; an out-of-range class never matches
   always_comb begin
      cls_ok   = 1'b0;
      sel_free = '0;
      rs_take  = '0;
      for (int i = 0; i < NUM_CLS; i++) begin
         if (issue_class == CLS_W'(i)) begin
            cls_ok   = 1'b1;
            sel_free = rs_cnt[i];
         end
      end
      res_ok       = cls_ok && (sel_free != '0) && (rob_cnt != '0);
      pc_stall     = (state != ST_RUN) || flush || (issue_valid && !res_ok);
      icache_stall = pc_stall || pc_locked;
      issue_fire   = issue_valid && !pc_stall && !pc_locked;
      for (int i = 0; i < NUM_CLS; i++) begin
         rs_take[i] = issue_fire && (issue_class == CLS_W'(i));
      end
   end

   // Flatten the per-class counters and expose the remaining status
   always_comb begin
      rs_free = '0;
      for (int i = 0; i < NUM_CLS; i++) begin
         rs_free[i*RS_CW +: RS_CW] = rs_cnt[i];
      end
      rob_free   = rob_cnt;
      in_flush   = (state == ST_FLUSH);
      credit_err = err_q;
   end

   // Control FSM and credit counters; flush overrides everything and refills all credits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_INIT;
         flush_cnt <= '0;
         rob_cnt   <= ROB_FULL;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_CLS; i++) begin
            rs_cnt[i] <= RS_FULL;
         end
      end else if (flush) begin
         state     <= ST_FLUSH;
         flush_cnt <= FC_LOAD;
         rob_cnt   <= ROB_FULL;
         for (int i = 0; i < NUM_CLS; i++) begin
            rs_cnt[i] <= RS_FULL;
         end
      end else begin
         case (state)
            ST_INIT: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               for (int i = 0; i < NUM_CLS; i++) begin
                  case ({rs_release[i], rs_take[i]})
                     2'b10: begin
                        if (rs_cnt[i] == RS_FULL) begin
                           err_q <= 1'b1;
                        end else begin
                           rs_cnt[i] <= rs_cnt[i] + 1'b1;
                        end
                     end
                     2'b01:   rs_cnt[i] <= rs_cnt[i] - 1'b1;
                     default: rs_cnt[i] <= rs_cnt[i];
                  endcase
               end
               case ({rob_commit, issue_fire})
                  2'b10: begin
                     if (rob_cnt == ROB_FULL) begin
                        err_q <= 1'b1;
                     end else begin
                        rob_cnt <= rob_cnt + 1'b1;
                     end
                  end
                  2'b01:   rob_cnt <= rob_cnt - 1'b1;
                  default: rob_cnt <= rob_cnt;
               endcase
            end
            ST_FLUSH: begin
               // Releases/commits are stale after a flush, so credits stay full
               rob_cnt <= ROB_FULL;
               for (int i = 0; i < NUM_CLS; i++) begin
                  rs_cnt[i] <= RS_FULL;
               end
               if (flush_cnt == '0) begin
                  state <= ST_RUN;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_issue_stall_ctrl.sv
// tb/tb_issue_stall_ctrl.sv - scoreboard bench for issue_stall_ctrl
module tb_issue_stall_ctrl;

   localparam int FLUSH_CYCLES = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       issue_valid = 1'b0;
   logic [1:0] issue_class = 2'd0;
   logic [2:0] rs_release = 3'd0;
   logic       rob_commit = 1'b0;
   logic       flush = 1'b0;
   logic       pc_locked = 1'b0;
   logic       issue_fire;
   logic       pc_stall;
   logic       icache_stall;
   logic [8:0] rs_free;
   logic [4:0] rob_free;
   logic       in_flush;
   logic       credit_err;

   issue_stall_ctrl #(
      .NUM_CLS(3), .RS_DEPTH(4), .ROB_DEPTH(16), .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_class(issue_class),
      .rs_release(rs_release), .rob_commit(rob_commit), .flush(flush),
      .pc_locked(pc_locked), .issue_fire(issue_fire), .pc_stall(pc_stall),
      .icache_stall(icache_stall), .rs_free(rs_free), .rob_free(rob_free),
      .in_flush(in_flush), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic       fire;
      logic       pcs;
      logic       ics;
      logic       inf;
      logic       err;
      logic [8:0] rs;
      logic [4:0] rob;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err = 0;
   int   step_id = 0;

   // reference model: 0=INIT 1=RUN 2=FLUSH
   int   m_state;
   int   m_cnt;
   int   m_rs[3];
   int   m_rob;
   bit   m_err;

   task automatic chk(input int id, input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL step %0d %s: observed %0h expected %0h", id, name, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_state = 0;
      m_cnt   = 0;
      m_rob   = 16;
      m_err   = 1'b0;
      for (int i = 0; i < 3; i++) m_rs[i] = 4;
   endtask

   task automatic step(input bit r, input bit v, input int cls, input logic [2:0] rel,
                       input bit com, input bit fl, input bit lk,
                       input bit ef, input bit ep, input bit ei);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; issue_valid = v; issue_class = 2'(cls); rs_release = rel;
      rob_commit = com; flush = fl; pc_locked = lk;
      if (!r) m_reset();
      e.id   = step_id;
      e.fire = ef;
      e.pcs  = ep;
      e.ics  = ei;
      e.inf  = (m_state == 2);
      e.err  = m_err;
      e.rs   = {3'(m_rs[2]), 3'(m_rs[1]), 3'(m_rs[0])};
      e.rob  = 5'(m_rob);
      sb.push_back(e);
      step_id++;
      if (r) begin
         if (fl) begin
            m_state = 2;
            m_cnt   = FLUSH_CYCLES - 1;
            m_rob   = 16;
            for (int i = 0; i < 3; i++) m_rs[i] = 4;
         end else if (m_state == 0) begin
            m_state = 1;
         end else if (m_state == 1) begin
            for (int i = 0; i < 3; i++) begin
               if (rel[i] && !(ef && cls == i)) begin
                  if (m_rs[i] == 4) m_err = 1'b1;
                  else m_rs[i] = m_rs[i] + 1;
               end else if (!rel[i] && ef && cls == i) begin
                  m_rs[i] = m_rs[i] - 1;
               end
            end
            if (com && !ef) begin
               if (m_rob == 16) m_err = 1'b1;
               else m_rob = m_rob + 1;
            end else if (!com && ef) begin
               m_rob = m_rob - 1;
            end
         end else begin
            if (m_cnt == 0) m_state = 1;
            else m_cnt = m_cnt - 1;
         end
      end
   endtask

   // pop one expectation per cycle and compare it mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk(e.id, "issue_fire",   32'(issue_fire),   32'(e.fire));
         chk(e.id, "pc_stall",     32'(pc_stall),     32'(e.pcs));
         chk(e.id, "icache_stall", 32'(icache_stall), 32'(e.ics));
         chk(e.id, "in_flush",     32'(in_flush),     32'(e.inf));
         chk(e.id, "credit_err",   32'(credit_err),   32'(e.err));
         chk(e.id, "rs_free",      32'(rs_free),      32'(e.rs));
         chk(e.id, "rob_free",     32'(rob_free),     32'(e.rob));
      end
   end

   initial begin
      m_reset();
      // reset, INIT cycle, idle RUN
      repeat (3) step(0,0,0,3'b000,0,0,0, 0,1,1);
      step(1,0,0,3'b000,0,0,0, 0,1,1);
      step(1,0,0,3'b000,0,0,0, 0,0,0);
      // class 1 exhaustion and resume after one release
      repeat (4) step(1,1,1,3'b000,0,0,0, 1,0,0);
      step(1,1,1,3'b000,0,0,0, 0,1,1);
      step(1,1,1,3'b010,0,0,0, 0,1,1);
      step(1,1,1,3'b000,0,0,0, 1,0,0);
      repeat (4) step(1,0,0,3'b010,0,0,0, 0,0,0);
      // simultaneous fire+release and fire+commit
      repeat (2) step(1,1,0,3'b000,0,0,0, 1,0,0);
      step(1,1,0,3'b001,0,0,0, 1,0,0);
      step(1,1,0,3'b000,1,0,0, 1,0,0);
      // ROB exhaustion with RS slots recycled
      for (int k = 0; k < 8; k++) step(1,1,k % 3,3'(1 << (k % 3)),0,0,0, 1,0,0);
      step(1,1,2,3'b000,0,0,0, 0,1,1);
      step(1,1,2,3'b000,1,0,0, 0,1,1);
      step(1,1,2,3'b000,0,0,0, 1,0,0);
      step(1,1,2,3'b000,0,0,0, 0,1,1);
      repeat (5) step(1,0,0,3'b000,1,0,0, 0,0,0);
      // flush at rob_free=5, releases ignored, fire on 3rd cycle
      step(1,0,0,3'b000,0,1,0, 0,1,1);
      step(1,1,0,3'b111,1,0,0, 0,1,1);
      step(1,1,0,3'b100,0,0,0, 0,1,1);
      step(1,1,0,3'b000,0,0,0, 1,0,0);
      // second flush inside the window restarts it
      step(1,0,0,3'b000,0,1,0, 0,1,1);
      step(1,1,0,3'b000,0,0,0, 0,1,1);
      step(1,1,0,3'b000,0,1,0, 0,1,1);
      step(1,1,0,3'b000,0,0,0, 0,1,1);
      step(1,1,0,3'b000,0,0,0, 0,1,1);
      step(1,1,0,3'b000,0,0,0, 1,0,0);
      step(1,0,0,3'b000,0,0,0, 0,0,0);
      // over-release error, pc_locked, out-of-range class
      step(1,0,0,3'b100,0,0,0, 0,0,0);
      step(1,0,0,3'b000,0,0,0, 0,0,0);
      step(1,1,2,3'b000,0,0,1, 0,0,1);
      step(1,1,3,3'b000,0,0,0, 0,1,1);
      step(1,1,3,3'b000,0,0,1, 0,1,1);
      // reset in the middle of a flush window
      step(1,0,0,3'b000,0,1,0, 0,1,1);
      step(1,0,0,3'b000,0,0,0, 0,1,1);
      step(0,0,0,3'b000,0,0,0, 0,1,1);
      step(1,0,0,3'b000,0,0,0, 0,1,1);
      step(1,1,1,3'b000,0,0,0, 1,0,0);
      step(1,0,0,3'b000,0,0,0, 0,0,0);
      @(negedge clk);
      #1;
      chk(step_id, "scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
